// File: rtl/tlc_phase_sequencer.sv
// N-phase traffic light sequencer. Each served phase runs GREEN -> YELLOW ->
// ALL_RED. Peak mode serves phases cyclically; off-peak mode serves phases on
// latched demand and otherwise rests on REST_PHASE.
module tlc_phase_sequencer #(
  parameter int                         NUM_PHASES = 3,
  parameter int                         TW         = 8,
  parameter logic [NUM_PHASES*TW-1:0]   GREEN_PEAK = {8'd16, 8'd32, 8'd32},
  parameter logic [NUM_PHASES*TW-1:0]   GREEN_OFF  = {8'd8, 8'd16, 8'd16},
  parameter int                         YELLOW_T   = 4,
  parameter int                         ALLRED_T   = 2,
  parameter int                         REST_PHASE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    peak,
  input  logic [NUM_PHASES-1:0]   sensor,
  output logic [2*NUM_PHASES-1:0] lights,
  output logic [2:0]              cur_phase,
  output logic [1:0]              state_o,
  output logic                    phase_done
);

  localparam logic [1:0] S_GREEN  = 2'd0;
  localparam logic [1:0] S_YELLOW = 2'd1;
  localparam logic [1:0] S_ALLRED = 2'd2;

  localparam logic [1:0] L_GREEN  = 2'd0;
  localparam logic [1:0] L_YELLOW = 2'd1;
  localparam logic [1:0] L_RED    = 2'd2;

  localparam logic [2:0] REST = 3'(REST_PHASE);

  logic [1:0]    state;
  logic [2:0]    cur;
  logic [TW-1:0] timer;
  logic [TW-1:0] gdur;
  logic [7:0]    req;

  logic [1:0]            nstate;
  logic [2:0]            nphase;
  logic                  expired;
  logic                  enter_green;
  logic [TW-1:0]         dur;
  logic [7:0]            cur_mask;
  logic [7:0]            nphase_mask;
  logic [7:0]            sensor8;
  logic [7:0]            req_n;
  logic [2:0]            off_next;
  logic [2:0]            peak_next;
  logic                  off_found;
  logic [2*NUM_PHASES-1:0] lights_n;

  // Per-phase green tables, padded to eight entries so a 3-bit phase indexes them directly
  logic [TW-1:0] gp_arr [8];
  logic [TW-1:0] go_arr [8];

  for (genvar g = 0; g < 8; g++) begin : g_tab
    if (g < NUM_PHASES) begin : g_used
      assign gp_arr[g] = GREEN_PEAK[g*TW +: TW];
      assign go_arr[g] = GREEN_OFF[g*TW +: TW];
    end else begin : g_pad
      assign gp_arr[g] = TW'(1);
      assign go_arr[g] = TW'(1);
    end
  end

  // A programmed duration of zero behaves as a one-cycle state
  function automatic logic [TW-1:0] eff_dur(input logic [TW-1:0] d);
    return (d == '0) ? TW'(1) : d;
  endfunction

  // Timer increments but sticks at all-ones so a long rest never wraps
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
    return (&t) ? t : t + TW'(1);
  endfunction

  // Phase index cur+k reduced modulo NUM_PHASES (k in 1..NUM_PHASES)
  function automatic logic [2:0] phase_add(input logic [2:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_PHASES) s = s - NUM_PHASES;
    return s[2:0];
  endfunction

  assign sensor8     = 8'(sensor);
  assign cur_mask    = 8'b1 << cur;
  assign nphase_mask = 8'b1 << nphase;
  assign peak_next   = phase_add(cur, 1);

  // Duration of the current state and whether this is its final cycle
  always_comb begin
    case (state)
      S_GREEN:  dur = eff_dur(gdur);
      S_YELLOW: dur = eff_dur(TW'(YELLOW_T));
      default:  dur = eff_dur(TW'(ALLRED_T));
    endcase
    expired = (timer >= dur - TW'(1));
  end

  // Off-peak successor: first requesting phase cyclically after cur, else rest phase
  always_comb begin
    off_next  = REST;
    off_found = 1'b0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      if (!off_found && req[phase_add(cur, k)]) begin
        off_next  = phase_add(cur, k);
        off_found = 1'b1;
      end
    end
  end

  // Next state / next phase. Off-peak green is left when another phase is
  // waiting, or when a non-rest phase has had its green so control can return
  // to the rest phase.
  always_comb begin
    nstate      = state;
    nphase      = cur;
    enter_green = 1'b0;
    case (state)
      S_GREEN: begin
        if (expired && (peak || |(req & ~cur_mask) || (cur != REST)))
          nstate = S_YELLOW;
      end
      S_YELLOW: begin
        if (expired) nstate = S_ALLRED;
      end
      S_ALLRED: begin
        if (expired) begin
          nstate      = S_GREEN;
          nphase      = peak ? peak_next : off_next;
          enter_green = 1'b1;
        end
      end
      default: begin
        nstate      = S_GREEN;
        enter_green = 1'b1;
      end
    endcase
  end

  // Demand latch: sensors on the green phase are ignored; entering green clears (clear wins)
  always_comb begin
    req_n = req | (sensor8 & ~((state == S_GREEN) ? cur_mask : 8'b0));
    if (enter_green) req_n = req_n & ~nphase_mask;
  end

  // Lamp codes for the state being entered, so lights change on the same edge as state
  always_comb begin
    lights_n = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (nstate == S_ALLRED || nphase != i[2:0])
        lights_n[2*i +: 2] = L_RED;
      else if (nstate == S_GREEN)
        lights_n[2*i +: 2] = L_GREEN;
      else
        lights_n[2*i +: 2] = L_YELLOW;
    end
  end

  // Sequencer registers with synchronous active-low reset to the rest phase green
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_GREEN;
      cur   <= REST;
      timer <= '0;
      req   <= '0;
      gdur  <= peak ? gp_arr[REST] : go_arr[REST];
      for (int i = 0; i < NUM_PHASES; i++)
        lights[2*i +: 2] <= (i == REST_PHASE) ? L_GREEN : L_RED;
    end else begin
      state  <= nstate;
      cur    <= nphase;
      timer  <= (nstate != state) ? '0 : sat_inc(timer);
      req    <= req_n;
      lights <= lights_n;
      if (enter_green) gdur <= peak ? gp_arr[nphase] : go_arr[nphase];
    end
  end

  assign cur_phase  = cur;
  assign state_o    = state;
  assign phase_done = (state == S_ALLRED) && expired;

endmodule
